jamma_input_scanner: RTL and testbench
======================================

Name: jamma_input_scanner

Overview:
- Parametrised successor to the 2-player JAMMA select toggle used in the arcade tops.
- Time-multiplexes the shared 8-bit JAMMA joystick bus across up to 4 players, with a settle delay after each select change.
- Debounces each player's bits per scan and merges player 0 with the on-board joystick.
- Conditions the coin inputs into fixed-width pulses.
- Sits between the board pins and the PACMAN-class core, replacing the inline joy_split logic.

Parameters:
- NUM_PLAYERS, 2, players scanned (1..4).
- BUS_W, 8, width of the shared JAMMA joystick bus.
- SETTLE_CYC, 3, pclk cycles to wait after a select change before sampling (>=1).
- DEBOUNCE_N, 3, consecutive identical samples of a player needed before a bit changes (>=1).
- COIN_HOLD, 16, pclk cycles the coin output is held asserted per accepted coin edge.

Ports:
- pclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scan_en  in  1  1 = scanner runs; 0 = FSM frozen, outputs hold.
- jjoy  in  BUS_W  shared JAMMA bus, active-low.
- local_joy  in  BUS_W  on-board joystick, active-low, merged into player 0.
- jcoin_n  in  NUM_PLAYERS  coin switches, active-low, asynchronous.
- jselect  out  2  binary index of the player currently driven onto the bus.
- joy_out  out  NUM_PLAYERS*BUS_W  debounced, active-low; player p occupies bits [p*BUS_W +: BUS_W].
- coin_out_n  out  NUM_PLAYERS  conditioned coin outputs, active-low.
- scan_done  out  1  one-cycle pulse after the last player's sample of each full scan.

Behaviour:
- Reset values:
  - jselect=0, FSM=SETTLE with settle counter 0.
  - All raw, stable and debounce counters: stable = all 1s, counters = 0.
  - joy_out = all 1s (idle); coin_out_n = all 1s; scan_done = 0.
- FSM states SETTLE and SAMPLE, active only while scan_en=1:
  - SETTLE: increment the settle counter each cycle. When it reaches SETTLE_CYC-1, go to SAMPLE next cycle.
  - SAMPLE (one cycle):
    - register jjoy as sample for player jselect;
    - jselect <= (jselect == NUM_PLAYERS-1) ? 0 : jselect+1;
    - clear the settle counter and return to SETTLE;
    - assert scan_done the next cycle if the sampled index was NUM_PLAYERS-1.
  - Scan period = NUM_PLAYERS*(SETTLE_CYC+1) cycles.
- NUM_PLAYERS=1: jselect stays 0 and scan_done pulses every SETTLE_CYC+1 cycles.
- scan_en=0 mid-settle: counter and state freeze; resume exactly where stopped. Coin logic keeps running.
- Debounce, per player p and bit b, evaluated only on p's sample cycle:
  - if sample == stable: cnt <= 0;
  - else cnt <= cnt+1, and when cnt+1 == DEBOUNCE_N, stable <= sample and cnt <= 0.
  - Glitch shorter than DEBOUNCE_N scans is rejected.
  - Latency from a steady bus change to joy_out change: DEBOUNCE_N samples of that player plus 1 cycle.
- joy_out is registered:
  - player 0 = stable[0] & local_joy (bitwise AND, active-low OR of presses);
  - other players = stable[p].
  - local_joy is not debounced. It passes through with 1 cycle latency, independent of scan_en.
- Coin path, per bit:
  - two-FF synchroniser, then falling-edge detect.
  - On an edge with the hold counter at 0: coin_out_n <= 0 for exactly COIN_HOLD cycles.
  - Edges during the hold are ignored, not extended.
  - A switch held low beyond the hold produces one pulse only; the next pulse needs release then press.
- Reset asserted mid-scan or mid-pulse: all state returns to reset values on the next edge. An in-flight coin pulse is aborted.
- Widths:
  - settle counter width covers SETTLE_CYC;
  - debounce counters cover DEBOUNCE_N;
  - hold counters cover COIN_HOLD;
  - no wrap is reachable on any counter.

Decomposition:
- Shared package jamma_pkg holds:
  - JAMMA_BUS_W=8, MAX_PLAYERS=4, SEL_W=2;
  - the scan FSM state enum {ST_SETTLE, ST_SAMPLE};
  - the active-low idle constant.
- One natural sub-module: jamma_coin_cond (synchroniser, edge detect, hold counter, one bit), instantiated NUM_PLAYERS times.
- The debounce is a generate loop in the top; it is not a separate module.

Test Plan:
- Reset check, defaults (2 players, SETTLE_CYC=3): after reset release, jselect sequence is 0,0,0,0,1,1,1,1,0. scan_done pulses at cycle 9, then every 8 cycles. joy_out = 16'hFFFF.
- Player-specific bus, DEBOUNCE_N=3: drive jjoy=8'hFE while jselect=1, 8'hFF otherwise. joy_out[15:8] becomes 8'hFE after the third player-1 sample, +1 cycle. joy_out[7:0] stays 8'hFF.
- Glitch rejection: player 0 bit 2 low for 2 consecutive player-0 samples, then high. joy_out[2] never changes. The 3-sample version flips it.
- Local merge: local_joy=8'hEF with jjoy idle. joy_out[7:0]=8'hEF one cycle later, with scan_en=0 as well.
- Coin, COIN_HOLD=16: jcoin_n[0] low for 40 cycles. coin_out_n[0] goes low 3 cycles after the edge, for exactly 16 cycles, once. A second press 5 cycles into the hold is ignored.
- scan_en and reset: drop scan_en at the second SETTLE cycle of player 1 for 10 cycles. jselect holds at 1, then completes the remaining 2 cycles. Reset during a coin pulse returns coin_out_n to 1 on the next edge.

Source files
------------

// File: rtl/jamma_pkg.sv
// Shared constants and types for the JAMMA input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jamma_pkg;

  localparam int JAMMA_BUS_W = 8;
  localparam int MAX_PLAYERS = 4;
  localparam int SEL_W       = 2;

  // Every JAMMA-side signal is active-low, so an idle (unpressed) bit reads 1.
  localparam logic IDLE_N = 1'b1;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/jamma_coin_cond.sv
// Coin conditioner for one switch: 2-FF synchroniser, falling-edge detect, fixed-width pulse.
// Latency: 3 pclk from the switch falling to coin_out_n falling; pulse lasts COIN_HOLD cycles.
// Backpressure: none; edges arriving while a pulse is in progress are dropped.
// Ports: pclk, reset (sync, active-high), coin_n (async switch, active-low),
//        coin_out_n (conditioned pulse, active-low).
module jamma_coin_cond
  import jamma_pkg::*;
#(
  parameter int COIN_HOLD = 16
) (
  input  logic pclk,
  input  logic reset,
  input  logic coin_n,
  output logic coin_out_n
);

  localparam int HOLD_W = $clog2(COIN_HOLD + 1);

  // [0],[1] are the synchroniser; [2] is the previous synchronised value for edge detection.
  logic [2:0]        sync_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              fall;

  assign fall = sync_q[2] & ~sync_q[1];

  always_ff @(posedge pclk) begin
    if (reset) begin
      sync_q     <= {3{IDLE_N}};
      hold_cnt   <= '0;
      coin_out_n <= IDLE_N;
    end else begin
      sync_q <= {sync_q[1:0], coin_n};
      if (hold_cnt != '0) begin
        // Pulse in progress: count it out and ignore any new edge.
        hold_cnt   <= hold_cnt - HOLD_W'(1);
        coin_out_n <= (hold_cnt == HOLD_W'(1));
      end else if (fall) begin
        hold_cnt   <= HOLD_W'(COIN_HOLD);
        coin_out_n <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jamma_input_scanner.sv
// Scans the shared JAMMA joystick bus across players, debounces each player, conditions coins.
// Latency: a steady bus change reaches joy_out DEBOUNCE_N player samples + 1 cycle later;
//          local_joy 1 cycle; coins 3 cycles.  Backpressure: none; scan_en=0 freezes the scan.
// Ports: pclk, reset (sync, active-high), scan_en, jjoy/local_joy (active-low buses),
//        jcoin_n (async coins), jselect (player on the bus), joy_out, coin_out_n, scan_done.
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BUS_W       = JAMMA_BUS_W,
  parameter int SETTLE_CYC  = 3,
  parameter int DEBOUNCE_N  = 3,
  parameter int COIN_HOLD   = 16
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic                         scan_en,
  input  logic [BUS_W-1:0]             jjoy,
  input  logic [BUS_W-1:0]             local_joy,
  input  logic [NUM_PLAYERS-1:0]       jcoin_n,
  output logic [SEL_W-1:0]             jselect,
  output logic [NUM_PLAYERS*BUS_W-1:0] joy_out,
  output logic [NUM_PLAYERS-1:0]       coin_out_n,
  output logic                         scan_done
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_N + 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PLAYERS - 1);

  scan_state_t       state, state_nxt;
  logic [SET_W-1:0]  settle_cnt, settle_cnt_nxt;
  logic [SEL_W-1:0]  jsel_nxt;
  logic              sample_en;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      jselect    <= '0;
      scan_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      jselect    <= jsel_nxt;
      scan_done  <= sample_en && (jselect == LAST_SEL);
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    jsel_nxt       = jselect;
    sample_en      = 1'b0;
    if (scan_en) begin
      case (state)
        ST_SETTLE: begin
          settle_cnt_nxt = settle_cnt + SET_W'(1);
          if (settle_cnt == SET_W'(SETTLE_CYC - 1))
            state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          sample_en      = 1'b1;
          settle_cnt_nxt = '0;
          state_nxt      = ST_SETTLE;
          jsel_nxt       = (jselect == LAST_SEL) ? '0 : jselect + SEL_W'(1);
        end
        default: state_nxt = ST_SETTLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [BUS_W-1:0] stable;
    logic [DB_W-1:0]  cnt [BUS_W];
    logic [BUS_W-1:0] joy_q;
    logic [BUS_W-1:0] merge_mask;

    // Only player 0 shares its slot with the on-board stick.
    assign merge_mask = (p == 0) ? local_joy : {BUS_W{IDLE_N}};

    // cnt counts consecutive samples disagreeing with stable; a mismatch run of
    // DEBOUNCE_N commits the new level, any agreeing sample restarts the run.
    always_ff @(posedge pclk) begin
      if (reset) begin
        stable <= {BUS_W{IDLE_N}};
        for (int b = 0; b < BUS_W; b++) cnt[b] <= '0;
      end else if (sample_en && (jselect == SEL_W'(p))) begin
        for (int b = 0; b < BUS_W; b++) begin
          if (jjoy[b] == stable[b]) begin
            cnt[b] <= '0;
          end else if (cnt[b] == DB_W'(DEBOUNCE_N - 1)) begin
            stable[b] <= jjoy[b];
            cnt[b]    <= '0;
          end else begin
            cnt[b] <= cnt[b] + DB_W'(1);
          end
        end
      end
    end

    always_ff @(posedge pclk) begin
      if (reset) joy_q <= {BUS_W{IDLE_N}};
      else       joy_q <= stable & merge_mask;
    end

    assign joy_out[p*BUS_W +: BUS_W] = joy_q;
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    jamma_coin_cond #(
      .COIN_HOLD (COIN_HOLD)
    ) u_coin (
      .pclk       (pclk),
      .reset      (reset),
      .coin_n     (jcoin_n[p]),
      .coin_out_n (coin_out_n[p])
    );
  end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of scan schedule, debounce and coin pulses.
// Ports: none (top-level bench).
module tb_jamma_input_scanner;

  localparam int NP = 2, BW = 8, SC = 3, DN = 3, CH = 16;
  localparam int PERIOD = NP * (SC + 1);

  logic            pclk = 1'b0;
  logic            reset = 1'b1;
  logic            scan_en = 1'b1;
  logic [BW-1:0]   jjoy = '1;
  logic [BW-1:0]   local_joy = '1;
  logic [NP-1:0]   jcoin_n = '1;
  logic [1:0]      jselect;
  logic [NP*BW-1:0] joy_out;
  logic [NP-1:0]   coin_out_n;
  logic            scan_done;

  always #5 pclk = ~pclk;

  jamma_input_scanner #(
    .NUM_PLAYERS (NP),
    .BUS_W       (BW),
    .SETTLE_CYC  (SC),
    .DEBOUNCE_N  (DN),
    .COIN_HOLD   (CH)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .scan_en    (scan_en),
    .jjoy       (jjoy),
    .local_joy  (local_joy),
    .jcoin_n    (jcoin_n),
    .jselect    (jselect),
    .joy_out    (joy_out),
    .coin_out_n (coin_out_n),
    .scan_done  (scan_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: the scan position is just the number of enabled cycles since reset;
  // a bit flips once the last DN samples of that player all disagree with it.
  int              en_cnt;
  logic [BW-1:0]   st [NP];
  logic [BW-1:0]   hist [NP][DN];
  int              hcnt [NP];
  logic [NP*BW-1:0] joy_exp;
  logic            sd_exp;
  logic [NP-1:0]   cp1, cp2, cp3;
  int              remain [NP];

  function automatic logic [1:0] jsel_exp();
    return 2'((en_cnt % PERIOD) / (SC + 1));
  endfunction

  function automatic logic [NP-1:0] coin_exp();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (remain[p] == 0);
    return r;
  endfunction

  task automatic model_edge();
    int ph, p;
    logic [NP-1:0] fall;
    logic all_diff;
    if (reset) begin
      en_cnt  = 0;
      sd_exp  = 1'b0;
      joy_exp = '1;
      for (int q = 0; q < NP; q++) begin
        st[q] = '1; hcnt[q] = 0; remain[q] = 0;
      end
      cp1 = '1; cp2 = '1; cp3 = '1;
    end else begin
      for (int q = 0; q < NP; q++)
        joy_exp[q*BW +: BW] = st[q] & ((q == 0) ? local_joy : 8'hFF);
      sd_exp = 1'b0;
      if (scan_en) begin
        ph = en_cnt % PERIOD;
        if (ph % (SC + 1) == SC) begin
          p = ph / (SC + 1);
          for (int i = DN - 1; i > 0; i--) hist[p][i] = hist[p][i-1];
          hist[p][0] = jjoy;
          if (hcnt[p] < DN) hcnt[p]++;
          if (hcnt[p] == DN) begin
            for (int b = 0; b < BW; b++) begin
              all_diff = 1'b1;
              for (int i = 0; i < DN; i++)
                if (hist[p][i][b] == st[p][b]) all_diff = 1'b0;
              if (all_diff) st[p][b] = ~st[p][b];
            end
          end
          sd_exp = (p == NP - 1);
        end
        en_cnt++;
      end
      // Coin seen as falling after two synchroniser stages.
      fall = cp3 & ~cp2;
      for (int q = 0; q < NP; q++) begin
        if (remain[q] != 0) remain[q]--;
        else if (fall[q]) remain[q] = CH;
      end
      cp3 = cp2; cp2 = cp1; cp1 = jcoin_n;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    chk("jselect", jselect, jsel_exp());
    chk("joy_out", joy_out, joy_exp);
    chk("coin_out_n", coin_out_n, coin_exp());
    chk("scan_done", scan_done, sd_exp);
  endtask

  task automatic run_scan(input logic [7:0] b0, input logic [7:0] b1);
    repeat (PERIOD) begin
      jjoy = (jsel_exp() == 0) ? b0 : b1;
      tick();
    end
  endtask

  logic [1:0] seq [9];
  logic [7:0] tgt [NP];
  int first, low_cycles;

  initial begin
    seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 0;
    seq[4] = 1; seq[5] = 1; seq[6] = 1; seq[7] = 1; seq[8] = 0;

    // Reset and initial scan sequence
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_jselect", jselect, 0);
    chk("rst_joy_out", joy_out, 16'hFFFF);
    chk("rst_coin", coin_out_n, 2'b11);
    chk("rst_scan_done", scan_done, 0);
    for (int i = 1; i < 9; i++) begin
      tick();
      chk("jsel_seq", jselect, seq[i]);
      if (i == 8) chk("scan_done_c9", scan_done, 1);
    end

    // Player-specific bus value
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      jjoy = (jsel_exp() == 1) ? 8'hFE : 8'hFF;
      tick();
      if (first < 0 && joy_out[15:8] == 8'hFE) first = i;
    end
    chk("p1_latency", first, 25);
    chk("p1_bus", joy_out, 16'hFEFF);
    repeat (3) run_scan(8'hFF, 8'hFF);

    // Glitch rejection on player 0 bit 2, then acceptance
    repeat (2) run_scan(8'hFB, 8'hFF);
    repeat (2) run_scan(8'hFF, 8'hFF);
    chk("glitch_rej", joy_out[7:0], 8'hFF);
    repeat (3) run_scan(8'hFB, 8'hFF);
    chk("glitch_accept", joy_out[7:0], 8'hFB);
    repeat (3) run_scan(8'hFF, 8'hFF);

    // Local stick merge while frozen
    scan_en = 1'b0;
    local_joy = 8'hEF;
    tick();
    chk("local_merge", joy_out[7:0], 8'hEF);
    local_joy = 8'hFF;
    tick();
    scan_en = 1'b1;

    // Coin pulse with a re-press during the hold
    first = -1;
    low_cycles = 0;
    for (int t = 1; t <= 50; t++) begin
      jcoin_n[0] = (t <= 3 || (t >= 6 && t <= 40)) ? 1'b0 : 1'b1;
      tick();
      if (coin_out_n[0] == 1'b0) begin
        low_cycles++;
        if (first < 0) first = t;
      end
    end
    chk("coin_start", first, 3);
    chk("coin_len", low_cycles, 16);

    // Freeze at the second settle cycle of player 1
    for (int g = 0; g < PERIOD && (en_cnt % PERIOD) != 5; g++) tick();
    chk("pause_pos", jselect, 1);
    scan_en = 1'b0;
    repeat (10) begin
      tick();
      chk("pause_jsel", jselect, 1);
    end
    scan_en = 1'b1;
    repeat (2) tick();
    chk("resume_jsel", jselect, 1);
    tick();
    chk("resume_wrap", jselect, 0);

    // Reset in the middle of a coin pulse
    jcoin_n[1] = 1'b0;
    repeat (6) tick();
    chk("coin1_inflight", coin_out_n[1], 0);
    reset = 1'b1;
    tick();
    chk("rst_coin_abort", coin_out_n, 2'b11);
    chk("rst_jsel2", jselect, 0);
    jcoin_n = '1;
    tick();
    reset = 1'b0;

    // Random traffic
    for (int q = 0; q < NP; q++) tgt[q] = 8'hFF;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) tgt[$urandom_range(0, NP-1)] = 8'($urandom);
      jjoy = tgt[jsel_exp()];
      if ($urandom_range(0, 9) == 0) jjoy = jjoy ^ 8'(1 << $urandom_range(0, 7));
      local_joy = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'hFF;
      scan_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) jcoin_n[$urandom_range(0, NP-1)] ^= 1'b1;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 500000);
    $fatal(1, "watchdog");
  end

endmodule
